hex_key_event_queue: RTL and testbench
======================================

HEX_KEY_EVENT_QUEUE -- requirements
Module: hex_key_event_queue

Interface
REQ-001 SHALL have parameter LOCKOUT_CYCLES, default 16: post-acceptance bounce-suppression window in clock cycles; legal range 2..65535.
REQ-002 SHALL have parameter DEPTH, default 4: queue entries; legal values are powers of two, 2..16.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clock, input, 1 bit: system clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port Code, input, 4 bits: key code 0x0-0xF from the keypad encoder; sampled only when Valid=1.
REQ-007 SHALL have port Valid, input, 1 bit: encoder key-detect strobe; may pulse repeatedly while a key bounces.
REQ-008 SHALL have port rd_ready, input, 1 bit: consumer is ready to take the head entry.
REQ-009 SHALL have port clr_ovf, input, 1 bit: synchronous clear of overflow.
REQ-010 SHALL have port rd_valid, output, 1 bit: queue non-empty and rd_code valid.
REQ-011 SHALL have port rd_code, output, 4 bits: head-of-queue key code.
REQ-012 SHALL have port count, output, clog2(DEPTH)+1 bits: current occupancy.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag, set when an accepted key was dropped.
REQ-014 SHALL have port key_event, output, 1 bit: one-cycle pulse, registered, in the cycle after a key is accepted.

Function
REQ-015 SHALL implement a 2-state FSM with states IDLE and LOCKOUT, plus a lockout down-counter lk_cnt and a 4-bit last_code register.
REQ-016 IDLE, Valid=1: SHALL accept Code, set last_code=Code and lk_cnt=LOCKOUT_CYCLES-1, and go to LOCKOUT.
REQ-017 IDLE, Valid=0: SHALL hold all state.
REQ-018 LOCKOUT, Valid=1 and Code==last_code: SHALL treat the strobe as bounce, not accept it, and reload lk_cnt=LOCKOUT_CYCLES-1.
REQ-019 LOCKOUT, Valid=1 and Code!=last_code: SHALL accept Code as a new key, update last_code, and reload lk_cnt.
REQ-020 LOCKOUT, Valid=0: SHALL decrement lk_cnt; when lk_cnt==0 and Valid=0, SHALL go to IDLE the next cycle.
REQ-021 On every accept, SHALL raise key_event for exactly one cycle, whether or not the push succeeds.
REQ-022 SHALL push on accept when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
REQ-023 SHALL drop an accepted code when count==DEPTH with no same-cycle pop, set overflow=1, and leave the queue contents unchanged.
REQ-024 SHALL pop when rd_valid=1 and rd_ready=1; rd_ready while empty has no effect.
REQ-025 Simultaneous push and pop: count SHALL be unchanged, the head SHALL advance, and the new entry SHALL be written at the tail.
REQ-026 Read and write pointers SHALL be clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full and empty SHALL be derived from pointer MSB and low-bit compare.
REQ-027 rd_code SHALL equal the head entry combinationally from registered storage; push-to-rd_valid latency SHALL be 1 cycle, with no write-through to the output in the push cycle.
REQ-028 rd_code and rd_valid SHALL be held stable while rd_valid=1 and rd_ready=0.
REQ-029 overflow SHALL stay set until clr_ovf=1; if clr_ovf and a new drop coincide, the set SHALL win.
REQ-030 Code SHALL be ignored whenever Valid=0; X on Code with Valid=0 SHALL NOT propagate.

Reset
REQ-031 On reset=0, SHALL immediately and asynchronously force: FSM=IDLE, lk_cnt=0, last_code=0, pointers=0, count=0, rd_valid=0, rd_code=0, overflow=0, key_event=0.
REQ-032 Queue storage need not be cleared on reset; rd_code SHALL read 0 whenever rd_valid=0.
REQ-033 Reset mid-lockout or with a non-empty queue SHALL discard all pending entries; the first Valid after reset release SHALL be accepted from IDLE.

Verification
REQ-034 Single press: Valid pulse with Code=0x5, rd_ready=0 -> key_event 1 cycle later, count=1, rd_valid=1, rd_code=0x5.
REQ-035 Bounce: Code=0x9 pulses at cycles 0, 3 and 10 with LOCKOUT_CYCLES=16 -> exactly one entry (0x9); FSM returns to IDLE 16 cycles after cycle 10.
REQ-036 New key in lockout: 0x3 then 0xC 2 cycles later -> two entries, popped in order 0x3, 0xC.
REQ-037 Overflow: 5 distinct keys with DEPTH=4 and no pops -> count=4, overflow=1, entries 0..3 intact; clr_ovf -> overflow=0.
REQ-038 Full with simultaneous push and pop: count stays 4, head advances, new code appears last; 2*DEPTH+1 push/pop cycles exercise pointer wrap.
REQ-039 Reset asserted mid-lockout with count=3 -> all outputs reach reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/hex_key_event_queue.sv
// hex_key_event_queue: keypad code debouncer with lockout and a small FIFO of accepted key codes.
module hex_key_event_queue #(
    parameter int LOCKOUT_CYCLES = 16,
    parameter int DEPTH          = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [3:0]                 Code,
    input  logic                       Valid,
    input  logic                       rd_ready,
    input  logic                       clr_ovf,
    output logic                       rd_valid,
    output logic [3:0]                 rd_code,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       key_event
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [15:0] RELOAD = 16'(LOCKOUT_CYCLES - 1);

    typedef enum logic {IDLE, LOCKOUT} state_t;

    state_t        state, state_n;
    logic [15:0]   lk_cnt, lk_n;
    logic [3:0]    last_code, last_n;
    logic          accept, push, pop, full, empty;
    logic [AW:0]   wp, rp;
    logic [3:0]    mem [DEPTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            lk_cnt    <= '0;
            last_code <= '0;
        end else begin
            state     <= state_n;
            lk_cnt    <= lk_n;
            last_code <= last_n;
        end
    end

    // Repeated strobes of the same code keep the window open; a different code is a new key.
    always_comb begin
        state_n = state;
        lk_n    = lk_cnt;
        last_n  = last_code;
        accept  = 1'b0;
        if (state == IDLE) begin
            if (Valid) begin
                accept  = 1'b1;
                last_n  = Code;
                lk_n    = RELOAD;
                state_n = LOCKOUT;
            end
        end else if (Valid) begin
            lk_n = RELOAD;
            if (Code != last_code) begin
                accept = 1'b1;
                last_n = Code;
            end
        end else if (lk_cnt == '0) begin
            state_n = IDLE;
        end else begin
            lk_n = lk_cnt - 1'b1;
        end
    end

    assign empty    = wp == rp;
    assign full     = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign pop      = !empty && rd_ready;
    assign push     = accept && (!full || pop);
    assign rd_valid = !empty;
    assign rd_code  = empty ? 4'h0 : mem[rp[AW-1:0]];
    assign count    = wp - rp;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wp        <= '0;
            rp        <= '0;
            overflow  <= 1'b0;
            key_event <= 1'b0;
        end else begin
            wp        <= push ? wp + 1'b1 : wp;
            rp        <= pop ? rp + 1'b1 : rp;
            overflow  <= (accept && !push) ? 1'b1 : clr_ovf ? 1'b0 : overflow;
            key_event <= accept;
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wp[AW-1:0]] <= Code;
    end
endmodule

// File: tb/tb_hex_key_event_queue.sv
// tb_hex_key_event_queue: directed and random stimulus against a timestamp/queue reference model.
module tb_hex_key_event_queue;
    localparam int L = 16;
    localparam int D = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] Code = 4'h0;
    logic       Valid = 1'b0;
    logic       rd_ready = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       rd_valid;
    logic [3:0] rd_code;
    logic [2:0] count;
    logic       overflow;
    logic       key_event;

    hex_key_event_queue #(.LOCKOUT_CYCLES(L), .DEPTH(D)) dut (
        .clock(clock), .reset(reset), .Code(Code), .Valid(Valid),
        .rd_ready(rd_ready), .clr_ovf(clr_ovf), .rd_valid(rd_valid),
        .rd_code(rd_code), .count(count), .overflow(overflow), .key_event(key_event)
    );

    always #5 clock = ~clock;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         t_last = 0;
    bit         has_t = 0;
    logic [3:0] last = 4'h0;
    logic [3:0] q[$];
    bit         ovf = 0;
    bit         ke = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("rd_valid", {7'd0, rd_valid}, {7'd0, q.size() != 0});
        chk("rd_code", {4'd0, rd_code}, {4'd0, (q.size() != 0) ? q[0] : 4'h0});
        chk("count", {5'd0, count}, 8'(q.size()));
        chk("overflow", {7'd0, overflow}, {7'd0, ovf});
        chk("key_event", {7'd0, key_event}, {7'd0, ke});
    endtask

    // A strobe is bounce only if it repeats the last code within L cycles of the previous strobe.
    task automatic tick(input bit v, input logic [3:0] c, input bit rdy, input bit clr);
        bit pop, acc;
        Valid = v; Code = v ? c : 4'bx; rd_ready = rdy; clr_ovf = clr;
        pop = (q.size() != 0) && rdy;
        acc = v && !(has_t && (cyc - t_last <= L) && c == last);
        if (v) begin t_last = cyc; has_t = 1; end
        if (acc) last = c;
        if (pop) void'(q.pop_front());
        if (acc && q.size() >= D) ovf = 1; else if (clr) ovf = 0;
        if (acc && q.size() < D) q.push_back(c);
        ke = acc;
        cyc++;
        @(posedge clock); #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b0; Valid = 1'b0; rd_ready = 1'b0; clr_ovf = 1'b0;
        q.delete(); ovf = 0; ke = 0; has_t = 0;
        #1;
        check_all();
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    initial begin
        #1;
        check_all();
        @(posedge clock); #1;
        reset = 1'b1;
        tick(1, 4'h5, 0, 0);
        chk("press_event", {7'd0, key_event}, 8'd1);
        chk("press_code", {4'd0, rd_code}, 8'h05);
        tick(0, 0, 1, 0);
        repeat (20) tick(0, 0, 0, 0);
        for (int i = 0; i < 44; i++) tick(i == 0 || i == 3 || i == 10 || i == 26 || i == 43, 4'h9, 0, 0);
        chk("bounce_count", {5'd0, count}, 8'd2);
        chk("bounce_code", {4'd0, rd_code}, 8'h09);
        repeat (3) tick(0, 0, 1, 0);
        repeat (20) tick(0, 0, 0, 0);
        tick(1, 4'h3, 0, 0);
        tick(0, 0, 0, 0);
        tick(1, 4'hC, 0, 0);
        chk("newkey_count", {5'd0, count}, 8'd2);
        tick(0, 0, 1, 0);
        chk("newkey_second", {4'd0, rd_code}, 8'h0C);
        tick(0, 0, 1, 0);
        for (int i = 1; i <= 5; i++) tick(1, 4'(i), 0, 0);
        chk("ovf_count", {5'd0, count}, 8'd4);
        chk("ovf_flag", {7'd0, overflow}, 8'd1);
        chk("ovf_head", {4'd0, rd_code}, 8'h01);
        tick(0, 0, 0, 1);
        chk("ovf_clear", {7'd0, overflow}, 8'd0);
        for (int i = 0; i <= 2 * D; i++) tick(1, 4'(i + 6), 1, 0);
        chk("wrap_count", {5'd0, count}, 8'd4);
        repeat (4) tick(0, 0, 1, 0);
        tick(1, 4'h1, 0, 0);
        tick(1, 4'h2, 0, 0);
        tick(1, 4'h3, 0, 0);
        do_reset();
        chk("reset_count", {5'd0, count}, 8'd0);
        tick(1, 4'h3, 0, 0);
        chk("post_reset_accept", {7'd0, key_event}, 8'd1);
        for (int i = 0; i < 400; i++)
            tick($urandom % 3 == 0, 4'($urandom_range(0, 3)), 1'($urandom % 2), $urandom % 16 == 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
